// File: rtl/sync_fifo_param.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo_param
// Description : Parametrised single-clock FIFO with occupancy count,
//               programmable almost-full / almost-empty flags, sticky
//               overflow / underflow error flags and a selectable read mode
//               (registered read or first-word-fall-through).
//
// Ports       :
//   clk          in   system clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   ena          in   global enable; 0 freezes all state and ignores requests
//   wr_en        in   write request
//   wr_data      in   [DATA_W] write data
//   rd_en        in   read / pop request
//   clr_err      in   clears overflow and underflow
//   rd_data      out  [DATA_W] read data
//   rd_valid     out  rd_data is valid
//   full         out  count == DEPTH
//   empty        out  count == 0
//   almost_full  out  count >= AF_THRESH
//   almost_empty out  count <= AE_THRESH
//   count        out  [$clog2(DEPTH)+1] current occupancy
//   overflow     out  sticky: write attempted while full
//   underflow    out  sticky: read attempted while empty
//
// Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo_param #(
    parameter int DATA_W    = 4,
    parameter int DEPTH     = 8,
    parameter int AF_THRESH = 6,
    parameter int AE_THRESH = 2,
    parameter bit FWFT      = 1'b0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       ena,
    input  logic                       wr_en,
    input  logic [DATA_W-1:0]          wr_data,
    input  logic                       rd_en,
    input  logic                       clr_err,
    output logic [DATA_W-1:0]          rd_data,
    output logic                       rd_valid,
    output logic                       full,
    output logic                       empty,
    output logic                       almost_full,
    output logic                       almost_empty,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow,
    output logic                       underflow
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;

    // Thresholds cast to the count width so every compare is width-matched.
    localparam logic [c_CNT_W-1:0] c_DEPTH = c_CNT_W'(DEPTH);
    localparam logic [c_CNT_W-1:0] c_AF    = c_CNT_W'(AF_THRESH);
    localparam logic [c_CNT_W-1:0] c_AE    = c_CNT_W'(AE_THRESH);

    logic [DATA_W-1:0]  r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0] r_count;
    logic               r_overflow;
    logic               r_underflow;

    logic w_full;
    logic w_empty;
    logic w_wa;
    logic w_ra;
    logic w_ovf_set;
    logic w_unf_set;

    // Status flags decode straight from the count register.
    assign w_full  = (r_count == c_DEPTH);
    assign w_empty = (r_count == '0);

    // Accept decisions use the pre-edge full/empty, so a write into a full
    // FIFO is refused even when a read frees a slot in the same cycle.
    assign w_wa      = ena & wr_en & ~w_full;
    assign w_ra      = ena & rd_en & ~w_empty;
    assign w_ovf_set = ena & wr_en & w_full;
    assign w_unf_set = ena & rd_en & w_empty;

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (w_wa) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wa) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_ra) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_wa, w_ra})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Sticky error flags; a set event in the same cycle beats clr_err.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else if (ena) begin
            if (w_ovf_set) begin
                r_overflow <= 1'b1;
            end else if (clr_err) begin
                r_overflow <= 1'b0;
            end
            if (w_unf_set) begin
                r_underflow <= 1'b1;
            end else if (clr_err) begin
                r_underflow <= 1'b0;
            end
        end
    end

    generate
        if (FWFT) begin : g_fwft
            // Head word is presented combinationally. It is forced to zero
            // while empty so the output is defined out of reset even though
            // the storage array is not.
            assign rd_data  = w_empty ? '0 : r_mem[r_rd_ptr];
            assign rd_valid = ~w_empty;
        end else begin : g_std
            logic [DATA_W-1:0] r_rd_data;
            logic              r_rd_valid;

            // rd_valid pulses for exactly the cycle after an accepted read;
            // rd_data keeps its last value otherwise. With ena low no read is
            // accepted, so rd_valid drops there too.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_rd_data  <= '0;
                    r_rd_valid <= 1'b0;
                end else begin
                    r_rd_valid <= w_ra;
                    if (w_ra) begin
                        r_rd_data <= r_mem[r_rd_ptr];
                    end
                end
            end

            assign rd_data  = r_rd_data;
            assign rd_valid = r_rd_valid;
        end
    endgenerate

    assign full         = w_full;
    assign empty        = w_empty;
    assign almost_full  = (r_count >= c_AF);
    assign almost_empty = (r_count <= c_AE);
    assign count        = r_count;
    assign overflow     = r_overflow;
    assign underflow    = r_underflow;

endmodule
`default_nettype wire

// File: tb/tb_sync_fifo_param.sv
`default_nettype none
// ============================================================================
// Module      : tb_sync_fifo_param
// Description : Self-checking bench for sync_fifo_param. One instance in
//               registered-read mode checked against a queue scoreboard and a
//               vector table, one instance in FWFT mode with a short directed
//               sequence.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sync_fifo_param;

    localparam int c_DEPTH = 8;

    logic       clk;
    logic       rst_n;

    // Registered-read instance
    logic       ena, wr_en, rd_en, clr_err;
    logic [3:0] wr_data;
    logic [3:0] rd_data;
    logic       rd_valid, full, empty, almost_full, almost_empty;
    logic [3:0] count;
    logic       overflow, underflow;

    // FWFT instance
    logic       f_ena, f_wr_en, f_rd_en, f_clr_err;
    logic [3:0] f_wr_data;
    logic [3:0] f_rd_data;
    logic       f_rd_valid, f_full, f_empty, f_almost_full, f_almost_empty;
    logic [3:0] f_count;
    logic       f_overflow, f_underflow;

    int n_total;
    int n_pass;

    // Scoreboard state
    logic [3:0] sb_q[$];
    bit         m_ov, m_un;
    logic [3:0] m_last;

    sync_fifo_param #(.DATA_W(4), .DEPTH(8), .AF_THRESH(6), .AE_THRESH(2), .FWFT(1'b0)) u_dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .wr_en(wr_en), .wr_data(wr_data),
        .rd_en(rd_en), .clr_err(clr_err), .rd_data(rd_data), .rd_valid(rd_valid),
        .full(full), .empty(empty), .almost_full(almost_full), .almost_empty(almost_empty),
        .count(count), .overflow(overflow), .underflow(underflow)
    );

    sync_fifo_param #(.DATA_W(4), .DEPTH(8), .AF_THRESH(6), .AE_THRESH(2), .FWFT(1'b1)) u_dut_fwft (
        .clk(clk), .rst_n(rst_n), .ena(f_ena), .wr_en(f_wr_en), .wr_data(f_wr_data),
        .rd_en(f_rd_en), .clr_err(f_clr_err), .rd_data(f_rd_data), .rd_valid(f_rd_valid),
        .full(f_full), .empty(f_empty), .almost_full(f_almost_full), .almost_empty(f_almost_empty),
        .count(f_count), .overflow(f_overflow), .underflow(f_underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Compare every registered-read output with the scoreboard's view.
    task automatic check_model(input bit exp_rv);
        int sz;
        sz = sb_q.size();
        chk("count",        int'(count),        sz);
        chk("full",         int'(full),         int'(sz == c_DEPTH));
        chk("empty",        int'(empty),        int'(sz == 0));
        chk("almost_full",  int'(almost_full),  int'(sz >= 6));
        chk("almost_empty", int'(almost_empty), int'(sz <= 2));
        chk("overflow",     int'(overflow),     int'(m_ov));
        chk("underflow",    int'(underflow),    int'(m_un));
        chk("rd_valid",     int'(rd_valid),     int'(exp_rv));
        chk("rd_data",      int'(rd_data),      int'(m_last));
    endtask

    // One clock on the registered-read instance: predict, drive, sample.
    task automatic cyc(input bit en, input bit wr, input logic [3:0] d,
                       input bit rd, input bit clr);
        bit was_full, was_empty, wa, ra;
        was_full  = (sb_q.size() == c_DEPTH);
        was_empty = (sb_q.size() == 0);
        wa = en && wr && !was_full;
        ra = en && rd && !was_empty;
        ena = en; wr_en = wr; wr_data = d; rd_en = rd; clr_err = clr;
        @(posedge clk);
        #1;
        if (ra) m_last = sb_q.pop_front();
        if (wa) sb_q.push_back(d);
        if (en) begin
            m_ov = (wr && was_full)  ? 1'b1 : (clr ? 1'b0 : m_ov);
            m_un = (rd && was_empty) ? 1'b1 : (clr ? 1'b0 : m_un);
        end
        check_model(ra);
    endtask

    typedef struct {
        bit         en;
        bit         wr;
        logic [3:0] d;
        bit         rd;
        bit         clr;
        int         exp_count;
        bit         exp_empty;
        bit         exp_rv;
        logic [3:0] exp_rd;
        bit         exp_un;
    } vec_t;

    vec_t vecs[8];

    initial begin
        n_total = 0; n_pass = 0;
        m_ov = 0; m_un = 0; m_last = 4'h0;
        rst_n = 1'b0;
        ena = 0; wr_en = 0; wr_data = 0; rd_en = 0; clr_err = 0;
        f_ena = 0; f_wr_en = 0; f_wr_data = 0; f_rd_en = 0; f_clr_err = 0;

        //          en wr d     rd clr cnt emp rv rd    un
        vecs[0] = '{1, 1, 4'hA, 0, 0,  1,  0,  0, 4'h0, 0};
        vecs[1] = '{1, 0, 4'h0, 1, 0,  0,  1,  1, 4'hA, 0};
        vecs[2] = '{1, 0, 4'h0, 0, 0,  0,  1,  0, 4'hA, 0};
        vecs[3] = '{0, 1, 4'h5, 0, 0,  0,  1,  0, 4'hA, 0};
        vecs[4] = '{1, 0, 4'h0, 1, 0,  0,  1,  0, 4'hA, 1};
        vecs[5] = '{1, 0, 4'h0, 1, 1,  0,  1,  0, 4'hA, 1};
        vecs[6] = '{0, 0, 4'h0, 0, 1,  0,  1,  0, 4'hA, 1};
        vecs[7] = '{1, 0, 4'h0, 0, 1,  0,  1,  0, 4'hA, 0};

        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Reset state of both instances
        check_model(1'b0);
        chk("fwft_reset_rd_valid", int'(f_rd_valid), 0);
        chk("fwft_reset_rd_data",  int'(f_rd_data),  0);
        chk("fwft_reset_empty",    int'(f_empty),    1);

        // Vector table: single write/read, ena gating, underflow vs clr_err
        for (int i = 0; i < 8; i++) begin
            cyc(vecs[i].en, vecs[i].wr, vecs[i].d, vecs[i].rd, vecs[i].clr);
            chk($sformatf("vec%0d_count", i), int'(count),     vecs[i].exp_count);
            chk($sformatf("vec%0d_empty", i), int'(empty),     int'(vecs[i].exp_empty));
            chk($sformatf("vec%0d_rv", i),    int'(rd_valid),  int'(vecs[i].exp_rv));
            chk($sformatf("vec%0d_rd", i),    int'(rd_data),   int'(vecs[i].exp_rd));
            chk($sformatf("vec%0d_un", i),    int'(underflow), int'(vecs[i].exp_un));
        end

        // Fill with 1..8; almost_full must first appear at count 6
        for (int v = 1; v <= 8; v++) begin
            cyc(1, 1, 4'(v), 0, 0);
            chk($sformatf("fill_af_at_%0d", v), int'(almost_full), int'(v >= 6));
        end
        chk("fill_full", int'(full), 1);
        chk("fill_count", int'(count), 8);

        // Ninth write rejected; simultaneous read still accepted when full
        cyc(1, 1, 4'hF, 0, 0);
        chk("ovf_set", int'(overflow), 1);
        chk("ovf_count", int'(count), 8);
        cyc(1, 1, 4'hF, 1, 0);
        chk("full_rd_first", int'(rd_data), 1);
        chk("full_rd_count", int'(count), 7);
        for (int v = 2; v <= 8; v++) begin
            cyc(1, 0, 4'h0, 1, 0);
            chk($sformatf("drain_%0d", v), int'(rd_data), v);
        end
        chk("drain_empty", int'(empty), 1);
        cyc(1, 0, 4'h0, 0, 1);
        chk("ovf_cleared", int'(overflow), 0);

        // Steady state at count 3 with continuous write+read across wraps
        for (int v = 0; v < 3; v++) cyc(1, 1, 4'(v), 0, 0);
        for (int v = 3; v < 23; v++) begin
            cyc(1, 1, 4'(v), 1, 0);
            chk($sformatf("steady_cnt_%0d", v), int'(count), 3);
            chk($sformatf("steady_out_%0d", v), int'(rd_data), (v - 3) & 4'hF);
        end

        // ena low with pending requests: no change, rd_valid drops
        cyc(0, 1, 4'h9, 1, 0);
        chk("ena0_count", int'(count), 3);
        chk("ena0_rv", int'(rd_valid), 0);

        // Mid-stream async reset with underflow set and 5 entries held
        while (sb_q.size() > 0) cyc(1, 0, 4'h0, 1, 0);
        cyc(1, 0, 4'h0, 1, 0);
        for (int v = 0; v < 5; v++) cyc(1, 1, 4'(v + 8), 0, 0);
        chk("pre_rst_count", int'(count), 5);
        chk("pre_rst_un", int'(underflow), 1);
        ena = 0; wr_en = 0; rd_en = 0; clr_err = 0;
        #2;
        rst_n = 1'b0;
        #1;
        sb_q.delete();
        m_ov = 0; m_un = 0; m_last = 4'h0;
        chk("async_rst_count", int'(count), 0);
        chk("async_rst_empty", int'(empty), 1);
        check_model(1'b0);
        #1;
        rst_n = 1'b1;
        cyc(1, 1, 4'h5, 0, 0);
        cyc(1, 0, 4'h0, 1, 0);
        chk("post_rst_data", int'(rd_data), 5);
        cyc(1, 0, 4'h0, 0, 0);

        // FWFT instance: word visible the cycle after its write, no rd_en
        f_ena = 1; f_wr_en = 1; f_wr_data = 4'hC;
        @(posedge clk);
        #1;
        f_wr_en = 0;
        chk("fwft_rv_after_wr", int'(f_rd_valid), 1);
        chk("fwft_data_after_wr", int'(f_rd_data), 4'hC);
        @(posedge clk);
        #1;
        chk("fwft_hold_data", int'(f_rd_data), 4'hC);
        chk("fwft_hold_count", int'(f_count), 1);
        f_rd_en = 1;
        @(posedge clk);
        #1;
        f_rd_en = 0;
        chk("fwft_pop_empty", int'(f_empty), 1);
        chk("fwft_pop_rv", int'(f_rd_valid), 0);

        // FWFT ordering with two entries
        f_wr_en = 1; f_wr_data = 4'h3;
        @(posedge clk);
        #1;
        f_wr_data = 4'h4;
        @(posedge clk);
        #1;
        f_wr_en = 0;
        chk("fwft_head_3", int'(f_rd_data), 4'h3);
        f_rd_en = 1;
        @(posedge clk);
        #1;
        f_rd_en = 0;
        chk("fwft_head_4", int'(f_rd_data), 4'h4);
        chk("fwft_count_1", int'(f_count), 1);
        chk("fwft_flags", int'({f_overflow, f_underflow, f_full}), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
